// File: rtl/spi_flash_seq_if.sv
// spi_flash_seq_if: host command bus, byte-engine handshake and flash-side
// status signals for the SPI flash command sequencer.
//   slave  - the sequencer (spi_flash_seq)
//   master - the host plus the SPI byte engine it talks to
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_len  host command request
//   byte_start/byte_tx, byte_done/byte_rx         one-byte transfer handshake
//   spi_cs_n                                      flash chip select (active low)
//   rd_valid/rd_data                              received read bytes
//   busy/done/err                                 command status
interface spi_flash_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        byte_start;
    logic [7:0]  byte_tx;
    logic        byte_done;
    logic [7:0]  byte_rx;
    logic        spi_cs_n;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic        err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, byte_done, byte_rx,
        output cmd_ready, byte_start, byte_tx, spi_cs_n, rd_valid, rd_data,
               busy, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, byte_done, byte_rx,
        input  cmd_ready, byte_start, byte_tx, spi_cs_n, rd_valid, rd_data,
               busy, done, err
    );
endinterface

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: sequences RDID / READ / RDSR commands to a SPI NOR flash
// through an external one-byte-at-a-time SPI byte engine.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    spi_flash_seq_if.slave (host command, byte engine, cs_n, read data,
//          busy/done/err status)
// Parameters:
//   CS_SETUP_CYC  cycles from spi_cs_n falling to the opcode byte_start
//   CS_HOLD_CYC   cycles spi_cs_n is held high after the last byte before done
module spi_flash_seq #(
    parameter int unsigned CS_SETUP_CYC = 2,
    parameter int unsigned CS_HOLD_CYC  = 2
) (
    input  logic            clk,
    input  logic            reset,
    spi_flash_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SEND_OP,
        S_SEND_ADDR,
        S_READ,
        S_CS_HOLD,
        S_FINISH
    } state_t;

    localparam logic [1:0] OP_RDID = 2'b00;
    localparam logic [1:0] OP_READ = 2'b01;
    localparam logic [1:0] OP_RDSR = 2'b10;

    // Timer reload values; a zero-cycle setup/hold skips the timed state.
    localparam logic [15:0] SETUP_LOAD = (CS_SETUP_CYC == 0) ? 16'd0 : 16'(CS_SETUP_CYC - 1);
    localparam logic [15:0] HOLD_LOAD  = (CS_HOLD_CYC  == 0) ? 16'd0 : 16'(CS_HOLD_CYC  - 1);

    function automatic logic [7:0] opcode_of(input logic [1:0] op);
        case (op)
            OP_RDID: opcode_of = 8'h9F;
            OP_READ: opcode_of = 8'h03;
            OP_RDSR: opcode_of = 8'h05;
            default: opcode_of = 8'h00;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        cs_n_q, cs_n_d;
    logic        byte_start_q, byte_start_d;
    logic [7:0]  byte_tx_q, byte_tx_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  op_q, op_d;
    logic [23:0] addr_q, addr_d;     // shifts left as address bytes go out
    logic [1:0]  aleft_q, aleft_d;   // address bytes still to send after the first
    logic [8:0]  rcnt_q, rcnt_d;     // read bytes remaining (256 when len==0)
    logic [15:0] tmr_q, tmr_d;       // cs setup / hold timer
    logic        wait_q, wait_d;     // a byte_start has been issued and not yet completed

    logic        xfer_done;

    // A byte_done only counts once its byte_start has gone out and while a
    // transfer phase is active; anything else is a stray pulse.
    assign xfer_done = bus.byte_done && wait_q &&
                       (state_q == S_SEND_OP || state_q == S_SEND_ADDR || state_q == S_READ);

    always_comb begin
        state_d      = state_q;
        cs_n_d       = cs_n_q;
        byte_start_d = 1'b0;
        byte_tx_d    = byte_tx_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        op_d         = op_q;
        addr_d       = addr_q;
        aleft_d      = aleft_q;
        rcnt_d       = rcnt_q;
        tmr_d        = tmr_q;
        wait_d       = wait_q | byte_start_q;
        if (xfer_done) begin
            wait_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d   = bus.cmd_op;
                    addr_d = bus.cmd_addr;
                    case (bus.cmd_op)
                        OP_RDID: rcnt_d = 9'd3;
                        OP_RDSR: rcnt_d = 9'd1;
                        default: rcnt_d = (bus.cmd_len == 8'd0) ? 9'd256 : {1'b0, bus.cmd_len};
                    endcase
                    if (bus.cmd_op == 2'b11) begin
                        // Reserved op: never touch the flash, report and finish.
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        cs_n_d = 1'b0;
                        if (CS_SETUP_CYC == 0) begin
                            byte_start_d = 1'b1;
                            byte_tx_d    = opcode_of(bus.cmd_op);
                            state_d      = S_SEND_OP;
                        end else begin
                            tmr_d   = SETUP_LOAD;
                            state_d = S_CS_SETUP;
                        end
                    end
                end
            end

            S_CS_SETUP: begin
                if (tmr_q == 16'd0) begin
                    byte_start_d = 1'b1;
                    byte_tx_d    = opcode_of(op_q);
                    state_d      = S_SEND_OP;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end

            S_SEND_OP: begin
                if (xfer_done) begin
                    byte_start_d = 1'b1;
                    if (op_q == OP_READ) begin
                        byte_tx_d = addr_q[23:16];
                        addr_d    = {addr_q[15:0], 8'h00};
                        aleft_d   = 2'd2;
                        state_d   = S_SEND_ADDR;
                    end else begin
                        byte_tx_d = 8'h00;
                        state_d   = S_READ;
                    end
                end
            end

            S_SEND_ADDR: begin
                if (xfer_done) begin
                    byte_start_d = 1'b1;
                    if (aleft_q == 2'd0) begin
                        byte_tx_d = 8'h00;
                        state_d   = S_READ;
                    end else begin
                        byte_tx_d = addr_q[23:16];
                        addr_d    = {addr_q[15:0], 8'h00};
                        aleft_d   = aleft_q - 2'd1;
                    end
                end
            end

            S_READ: begin
                if (xfer_done) begin
                    rd_data_d  = bus.byte_rx;
                    rd_valid_d = 1'b1;
                    rcnt_d     = rcnt_q - 9'd1;
                    if (rcnt_q == 9'd1) begin
                        // Last byte: cs_n rises together with its rd_valid.
                        cs_n_d = 1'b1;
                        if (CS_HOLD_CYC == 0) begin
                            done_d  = 1'b1;
                            state_d = S_FINISH;
                        end else begin
                            tmr_d   = HOLD_LOAD;
                            state_d = S_CS_HOLD;
                        end
                    end else begin
                        byte_start_d = 1'b1;
                        byte_tx_d    = 8'h00;
                    end
                end
            end

            S_CS_HOLD: begin
                if (tmr_q == 16'd0) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cs_n_q       <= 1'b1;
            byte_start_q <= 1'b0;
            byte_tx_q    <= 8'h00;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= 8'h00;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            op_q         <= 2'b00;
            addr_q       <= 24'h0;
            aleft_q      <= 2'd0;
            rcnt_q       <= 9'd0;
            tmr_q        <= 16'd0;
            wait_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_n_q       <= cs_n_d;
            byte_start_q <= byte_start_d;
            byte_tx_q    <= byte_tx_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            aleft_q      <= aleft_d;
            rcnt_q       <= rcnt_d;
            tmr_q        <= tmr_d;
            wait_q       <= wait_d;
        end
    end

    // cmd_ready is held low while reset is asserted, high in IDLE otherwise.
    assign bus.cmd_ready  = (state_q == S_IDLE) && !reset;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.spi_cs_n   = cs_n_q;
    assign bus.byte_start = byte_start_q;
    assign bus.byte_tx    = byte_tx_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Testbench for spi_flash_seq: table of commands driven through a host task,
// byte engine stand-in with random latency, scoreboard queues for expected
// MOSI bytes and read data, plus directed reset and back-to-back sequences.
module tb_spi_flash_seq;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_flash_seq_if bif ();

    spi_flash_seq #(.CS_SETUP_CYC(SETUP), .CS_HOLD_CYC(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // scoreboard queues
    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] eng_q[$];

    // monitor state
    int   cyc = 0;
    int   xfers_left = 0;
    int   exp_start = -1;
    int   cs_fall_cyc = 0, last_bd_cyc = 0, last_done_cyc = 0, accept_cyc = 0;
    int   bs_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, cs_fall_cnt = 0, acc_cnt = 0;
    bit   first_bs = 0;
    logic prev_cs = 1'b1;
    bit   prev_rst = 1'b1;
    logic [7:0] last_rd = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            xfers_left = 0;
            exp_start  = -1;
            chk("ready_in_reset", bif.cmd_ready, 0);
        end else begin
            if (bif.cmd_valid && bif.cmd_ready) begin
                accept_cyc = cyc;
                acc_cnt++;
                case (bif.cmd_op)
                    2'b00:   xfers_left = 4;
                    2'b10:   xfers_left = 2;
                    2'b01:   xfers_left = 4 + ((bif.cmd_len == 8'd0) ? 256 : int'(bif.cmd_len));
                    default: xfers_left = 0;
                endcase
            end
            if (!bif.spi_cs_n && prev_cs) begin
                cs_fall_cyc = cyc;
                cs_fall_cnt++;
                first_bs = 1;
            end
            if (bif.spi_cs_n && !prev_cs && !prev_rst) begin
                chk("cs_rise_with_last_rd", bif.rd_valid, 1);
                chk("cs_rise_after_last_done", cyc, last_bd_cyc + 1);
            end
            if (bif.byte_start) begin
                bs_cnt++;
                chk("cs_low_at_start", bif.spi_cs_n, 0);
                chk("start_expected", tx_q.size() != 0, 1);
                if (tx_q.size() != 0) chk("byte_tx", bif.byte_tx, tx_q.pop_front());
                if (first_bs) chk("cs_setup", cyc - cs_fall_cyc, SETUP);
                first_bs = 0;
                if (exp_start >= 0) chk("start_gap", cyc, exp_start);
                exp_start = -1;
            end else if (exp_start >= 0 && cyc >= exp_start) begin
                chk("start_gap", bif.byte_start, 1);
                exp_start = -1;
            end
            if (bif.byte_done && xfers_left > 0) begin
                xfers_left--;
                last_bd_cyc = cyc;
                if (xfers_left > 0) exp_start = cyc + 1;
            end
            if (bif.rd_valid) begin
                rd_cnt++;
                last_rd = bif.rd_data;
                chk("rd_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) chk("rd_data", bif.rd_data, rd_q.pop_front());
            end
            if (bif.err) begin
                err_cnt++;
                chk("err_with_done", bif.done, 1);
            end
            if (bif.done) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (bif.err) chk("err_done_after_accept", cyc, accept_cyc + 1);
                else         chk("hold_to_done", cyc - last_bd_cyc, HOLD + 1);
            end
        end
        prev_cs  = bif.spi_cs_n;
        prev_rst = reset;
    end

    // SPI byte engine stand-in: one transfer at a time, 1..3 cycle latency
    initial begin
        bif.byte_done = 1'b0;
        bif.byte_rx   = 8'h00;
        forever begin
            @(negedge clk);
            if (bif.byte_start && !reset) begin
                int lat;
                logic [7:0] r;
                lat = 1 + int'($urandom_range(0, 2));
                r = (eng_q.size() != 0) ? eng_q.pop_front() : 8'h00;
                repeat (lat) @(posedge clk);
                #1;
                bif.byte_done = 1'b1;
                bif.byte_rx   = r;
                @(posedge clk);
                #1;
                bif.byte_done = 1'b0;
                bif.byte_rx   = 8'hEE;
            end
        end
    end

    // Push the expected MOSI bytes, engine responses and read data for a command
    task automatic push_exp(input logic [1:0] op, input logic [23:0] addr,
                            input logic [7:0] len, input logic [7:0] d0);
        logic [7:0] rdid[3];
        logic [7:0] v;
        int n;
        rdid[0] = 8'h20; rdid[1] = 8'hBA; rdid[2] = 8'h16;
        if (op == 2'b11) return;
        tx_q.push_back(op == 2'b00 ? 8'h9F : (op == 2'b01 ? 8'h03 : 8'h05));
        eng_q.push_back(8'hFF);
        if (op == 2'b01) begin
            tx_q.push_back(addr[23:16]);
            tx_q.push_back(addr[15:8]);
            tx_q.push_back(addr[7:0]);
            repeat (3) eng_q.push_back(8'hFF);
        end
        n = (op == 2'b00) ? 3 : (op == 2'b10) ? 1 : ((len == 8'd0) ? 256 : int'(len));
        for (int i = 0; i < n; i++) begin
            v = (op == 2'b00) ? rdid[i] : 8'(d0 + 8'(i));
            tx_q.push_back(8'h00);
            eng_q.push_back(v);
            rd_q.push_back(v);
        end
    endtask

    task automatic wait_accept();
        bit got = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bif.cmd_ready) begin got = 1; break; end
        end
        chk("accept_timeout", got, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (bif.done) begin got = 1; break; end
        end
        chk("done_timeout", got, 1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [23:0] addr,
                         input logic [7:0] len, input logic [7:0] d0, input bit wdone);
        push_exp(op, addr, len, d0);
        @(posedge clk);
        #1;
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.cmd_addr  = addr;
        bif.cmd_len   = len;
        wait_accept();
        bif.cmd_valid = 1'b0;
        if (wdone) wait_done();
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [23:0] addr;
        logic [7:0]  len;
        logic [7:0]  d0;
        int          nrd;
        int          nxfer;
        bit          er;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int b0, r0, d0c, e0, c0, a0;
        vecs[0] = '{2'b00, 24'h000000, 8'd0, 8'h00,   3,   4, 1'b0};
        vecs[1] = '{2'b01, 24'h012345, 8'd2, 8'hA0,   2,   6, 1'b0};
        vecs[2] = '{2'b10, 24'h000000, 8'd0, 8'h3C,   1,   2, 1'b0};
        vecs[3] = '{2'b11, 24'h000000, 8'd0, 8'h00,   0,   0, 1'b1};
        vecs[4] = '{2'b01, 24'hFFFFFE, 8'd3, 8'h10,   3,   7, 1'b0};
        vecs[5] = '{2'b01, 24'h000000, 8'd0, 8'h00, 256, 260, 1'b0};
        vecs[6] = '{2'b01, 24'hABCDEF, 8'd1, 8'h77,   1,   5, 1'b0};

        bif.cmd_valid = 1'b0;
        bif.cmd_op    = 2'b00;
        bif.cmd_addr  = 24'h0;
        bif.cmd_len   = 8'h0;

        // reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", bif.cmd_ready, 1);
        chk("rst_cs_n", bif.spi_cs_n, 1);
        chk("rst_busy", bif.busy, 0);
        chk("rst_start", bif.byte_start, 0);
        chk("rst_tx", bif.byte_tx, 0);
        chk("rst_rdv", bif.rd_valid, 0);
        chk("rst_rdd", bif.rd_data, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_err", bif.err, 0);

        // table of commands
        for (int v = 0; v < 7; v++) begin
            b0 = bs_cnt; r0 = rd_cnt; d0c = done_cnt; e0 = err_cnt; c0 = cs_fall_cnt;
            issue(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].d0, 1'b1);
            repeat (3) @(negedge clk);
            chk("n_rd", rd_cnt - r0, vecs[v].nrd);
            chk("n_start", bs_cnt - b0, vecs[v].nxfer);
            chk("n_done", done_cnt - d0c, 1);
            chk("n_err", err_cnt - e0, vecs[v].er);
            chk("n_cs_fall", cs_fall_cnt - c0, !vecs[v].er);
            chk("tx_left", tx_q.size(), 0);
            chk("rd_left", rd_q.size(), 0);
            chk("idle_ready", bif.cmd_ready, 1);
            chk("idle_busy", bif.busy, 0);
            chk("idle_cs_n", bif.spi_cs_n, 1);
            if (!vecs[v].er) chk("tx_hold", bif.byte_tx, 8'h00);
        end

        // reset during the second address byte of a READ
        begin
            int n = 0;
            issue(2'b01, 24'h123456, 8'd4, 8'h40, 1'b0);
            for (int k = 0; k < 200 && n < 3; k++) begin
                @(negedge clk);
                if (bif.byte_start) n++;
            end
            chk("addr2_reached", n, 3);
            @(posedge clk);
            #1 reset = 1'b1;
            d0c = done_cnt; c0 = cs_fall_cnt;
            @(posedge clk);
            #1 reset = 1'b0;
            tx_q.delete(); rd_q.delete(); eng_q.delete();
            @(negedge clk);
            chk("mid_rst_cs_n", bif.spi_cs_n, 1);
            chk("mid_rst_busy", bif.busy, 0);
            chk("mid_rst_start", bif.byte_start, 0);
            chk("mid_rst_tx", bif.byte_tx, 0);
            chk("mid_rst_rdd", bif.rd_data, 0);
            chk("mid_rst_done", bif.done, 0);
            chk("mid_rst_ready", bif.cmd_ready, 1);
            repeat (8) @(negedge clk);
            chk("no_done_after_rst", done_cnt - d0c, 0);
            chk("no_cs_after_rst", cs_fall_cnt - c0, 0);
            r0 = rd_cnt;
            issue(2'b10, 24'h0, 8'd0, 8'h02, 1'b1);
            repeat (2) @(negedge clk);
            chk("rdsr_after_rst_n", rd_cnt - r0, 1);
            chk("rdsr_after_rst_data", last_rd, 8'h02);
        end

        // cmd_valid held high across two commands
        begin
            bit got = 0;
            b0 = bs_cnt; r0 = rd_cnt; a0 = acc_cnt;
            push_exp(2'b10, 24'h0, 8'd0, 8'h5A);
            push_exp(2'b00, 24'h0, 8'd0, 8'h00);
            @(posedge clk);
            #1;
            bif.cmd_valid = 1'b1;
            bif.cmd_op    = 2'b10;
            wait_accept();
            bif.cmd_op = 2'b00;
            for (int k = 0; k < 500; k++) begin
                @(negedge clk);
                if (bif.cmd_ready) begin got = 1; break; end
            end
            chk("second_accept_timeout", got, 1);
            @(posedge clk);
            #1 bif.cmd_valid = 1'b0;
            chk("accept_after_done", accept_cyc, last_done_cyc + 1);
            wait_done();
            repeat (3) @(negedge clk);
            chk("held_accepts", acc_cnt - a0, 2);
            chk("held_starts", bs_cnt - b0, 6);
            chk("held_rd", rd_cnt - r0, 4);
            chk("held_tx_left", tx_q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end
endmodule
